// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder built around a single shared
// 1-bit full-adder cell. Operands are shifted out LSB first, one bit per
// clock, and the result is assembled in a shift register.
// Optional build macro SERIAL_SUB_EN adds a 'sub' input so the same datapath
// also computes A-B (B inverted at capture, carry preset to 1).

// Structural 1-bit full adder cell shared by the serial sequencer.
module full_adder (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    logic axb;

    assign axb   = a ^ b;
    assign sum   = axb ^ c_in;
    assign c_out = (a & b) | (axb & c_in);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_cat;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             last_bit;

    // The one shared adder cell: current LSBs plus the running carry.
    full_adder u_fa (
        .c_out (fa_cout),
        .sum   (fa_sum),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry)
    );

    // Operand B and initial carry as loaded on an accepted start.
    always_comb begin
        b_load     = b_in;
        carry_load = c_in;
`ifdef SERIAL_SUB_EN
        if (sub) begin
            b_load     = ~b_in;
            carry_load = 1'b1;
        end
`endif
    end

    // New sum bit enters at the MSB; after the final bit this is the full result.
    assign res_cat  = {fa_sum, res_sr};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Sequencer: operand capture, bit-serial shifting and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_cat[WIDTH-1:1];
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry flop still holds the carry into the MSB here
                        sum_out <= res_cat;
                        c_out   <= fa_cout;
                        ovf     <= carry ^ fa_cout;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // The edge closing DONE doubles as the next launch slot so
                    // back-to-back ops repeat every WIDTH+1 cycles.
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomized checks of serial_add_ctrl
// against a plain-arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             sub_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             ovf;

    int vectors;
    int miscompares;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
`ifdef SERIAL_SUB_EN
        .sub     (sub_sel),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, c_out, sum} using integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sb);
        int unsigned ua, ub, total;
        int sa, sbv, sres;
        logic [WIDTH-1:0] s;
        logic co, ov;
        ua = a;
        ub = b;
        sa  = (a >= 2**(WIDTH-1)) ? int'(a) - 2**WIDTH : int'(a);
        sbv = (b >= 2**(WIDTH-1)) ? int'(b) - 2**WIDTH : int'(b);
        if (sb) begin
            total = ua + (2**WIDTH - 1 - ub) + 1;
            sres  = sa - sbv;
        end else begin
            total = ua + ub + cin;
            sres  = sa + sbv + int'(cin);
        end
        s  = total[WIDTH-1:0];
        co = (total >= 2**WIDTH);
        ov = (sres > 2**(WIDTH-1) - 1) || (sres < -(2**(WIDTH-1)));
        return {ov, co, s};
    endfunction

    logic [WIDTH+1:0] last_exp;

    // Launch one op, check latency, outputs, and the return to idle.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic sb);
        logic [WIDTH+1:0] e;
        int n;
        e = model(a, b, cin, sb);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; c_in = cin; sub_sel = sb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); c_in = 1'($urandom);
        sub_sel = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".hold"}, 32'({ovf, c_out, sum_out}), 32'(last_exp));
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done) break;
        end
        check({tag, ".latency"}, 32'(n), 32'(WIDTH));
        check({tag, ".sum"}, 32'(sum_out), 32'(e[WIDTH-1:0]));
        check({tag, ".cout"}, 32'(c_out), 32'(e[WIDTH]));
        check({tag, ".ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, ".stable"}, 32'({ovf, c_out, sum_out}), 32'(e));
        last_exp = e;
    endtask

    initial begin
        logic [WIDTH+1:0] e;
        int pulses;
        int prev_t;
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;
        vectors = 0;
        miscompares = 0;
        last_exp = '0;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0; sub_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 32'({busy, done, ovf, c_out, sum_out}), 32'd0);
        rst_n = 1'b1;

        do_op("d5a33", 8'h5A, 8'h33, 1'b0, 1'b0);
        do_op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("d0000c", 8'h00, 8'h00, 1'b1, 1'b0);

        // Start re-asserted while running must be ignored.
        e = model(8'hC3, 8'h4E, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; a_in = 8'hC3; b_in = 8'h4E; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore.pulses", 32'(pulses), 32'd1);
        check("ignore.result", 32'({ovf, c_out, sum_out}), 32'(e));
        last_exp = e;

        // Reset in the middle of an op.
        @(negedge clk);
        start = 1'b1; a_in = 8'h77; b_in = 8'h11; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.outputs", 32'({busy, done, ovf, c_out, sum_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort.no_done", 32'(pulses), 32'd0);
        check("abort.after", 32'({busy, ovf, c_out, sum_out}), 32'd0);
        last_exp = '0;
        do_op("post_abort", 8'h10, 8'h20, 1'b0, 1'b0);

        // Start held high: back-to-back ops every WIDTH+1 cycles.
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h02; c_in = 1'b0;
        pulses = 0;
        prev_t = -1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held.sum", 32'(sum_out), 32'h03);
                if (prev_t >= 0) check("held.spacing", 32'(t - prev_t), 32'(WIDTH + 1));
                prev_t = t;
            end
        end
        check("held.count", 32'(pulses), 32'd3);
        start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
        last_exp = {2'b00, 8'h03};

`ifdef SERIAL_SUB_EN
        do_op("sub1001", 8'h10, 8'h01, 1'b0, 1'b1);
        do_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op("rand", ra, rb, rc, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
